fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoder/control logic. Holds the program counter, issues one word request at a time to instruction memory over a valid/ready handshake, and presents the returned instruction and its PC to decode through a valid/ready handshake. It accepts redirects (jal/jalr targets selected by `pc_select`) from the execute path. Any in-flight or held instruction on the old path is discarded.

---
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
// Instruction fetch stage feeding the decoder. Holds the program counter,
// issues at most one word request at a time to instruction memory and
// presents the returned instruction with its PC to decode. Redirects from the
// execute path (jal/jalr) replace the PC and discard any in-flight or held
// instruction fetched on the old path.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   redirect_valid/_pc        branch/jump request and target address
//   imem_req_valid/_addr      fetch request to memory (addr = PC)
//   imem_req_ready            memory accepts the request
//   imem_resp_valid/_data     returned instruction word
//   inst_valid/inst/inst_pc   instruction presented to decode
//   inst_ready                decode consumes the instruction
//   fetch_error               misaligned-redirect trap indicator
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with bit 1 set enters HALT (fetch_error=1)
//               until reset; only bit 0 of the target is cleared.
//   undefined : targets are forced word-aligned and fetch_error is tied 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_error
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [31:0] target_s;
  logic        misalign_s;

  // Bit 0 is always dropped (jalr); without the trap, bit 1 is dropped too.
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_s   = redirect_pc & 32'hFFFF_FFFE;
  assign misalign_s = target_s[1];
`else
  assign target_s   = redirect_pc & 32'hFFFF_FFFC;
  assign misalign_s = 1'b0;
`endif

  // State and datapath registers; reset returns to IDLE at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = target_s;
          // An accepted request still carries the old address: its
          // response must be discarded.
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) begin
              pc_d = target_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = target_s;
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // A redirect wins over decode backpressure: the held word is either
        // consumed this cycle or flushed.
        if (redirect_valid) begin
          pc_d    = target_s;
          state_d = S_REQ;
        end else if (inst_ready) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect target: PC is still updated above, then trap.
    if (redirect_valid && misalign_s &&
        (state_q == S_REQ || state_q == S_WAIT || state_q == S_HOLD)) begin
      state_d = S_HALT;
      kill_d  = 1'b0;
    end else begin
      kill_d  = kill_d;
    end
`endif
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_error    = (state_q == S_HALT);
`else
  assign fetch_error    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit          TRAP_EN  = 1'b1;
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFE;
`else
  localparam bit          TRAP_EN  = 1'b0;
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_error;

  // second instance for the PC wrap case
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = 32'd0;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_fetch_error;

  fetch_unit #(.RESET_PC(RST_PC)) u_dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_error(fetch_error)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(1'b1), .fetch_error(w_fetch_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // behavioural model: "started" = past the idle cycle, "out" = a request is
  // outstanding, "stale" = that request's data must be dropped, "held" = an
  // instruction is offered to decode, "halt" = trapped
  logic        m_started, m_out, m_stale, m_held, m_halt;
  logic [31:0] m_pc, m_inst, m_ipc;
  int          m_consumed = 0;
  int          hs_cnt = 0;

  // memory environment
  int          lat = 1;
  int          rem = 0;
  logic [31:0] pend_addr = 32'd0;
  bit          stray = 1'b0;

  logic [31:0] wq[$];
  logic [31:0] wiq[$];
  logic [31:0] wpq[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    else return {a[23:0], 8'h13};
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_halt = 1'b0;
    m_pc = RST_PC; m_inst = 32'd0; m_ipc = 32'd0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    rem = 0; stray = 1'b0;
    imem_resp_valid = 1'b0; w_resp_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one clock: predict from current inputs, advance, then drive memory
  task automatic tick();
    logic [31:0] t, acc_addr, w_addr;
    logic        mis, acc, w_acc;
    logic        n_started, n_out, n_stale, n_held, n_halt;
    logic [31:0] n_pc, n_inst, n_ipc;
    acc = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
    w_acc = w_req_valid;
    w_addr = w_req_addr;
    if (w_req_valid) wq.push_back(w_req_addr);
    if (w_inst_valid) begin wiq.push_back(w_inst); wpq.push_back(w_inst_pc); end
    if (inst_valid && inst_ready) hs_cnt++;
    if (m_held && inst_ready) m_consumed++;
    n_started = m_started; n_out = m_out; n_stale = m_stale; n_held = m_held;
    n_halt = m_halt; n_pc = m_pc; n_inst = m_inst; n_ipc = m_ipc;
    t = redirect_pc & TGT_MASK;
    mis = TRAP_EN && t[1];
    if (!m_started) begin
      n_started = 1'b1;
    end else if (m_halt) begin
      n_halt = 1'b1;
    end else if (redirect_valid && mis) begin
      n_halt = 1'b1; n_pc = t; n_out = 1'b0; n_held = 1'b0; n_stale = 1'b0;
    end else if (m_held) begin
      if (redirect_valid) begin n_held = 1'b0; n_pc = t; end
      else if (inst_ready) n_held = 1'b0;
    end else if (m_out) begin
      if (imem_resp_valid) begin
        n_out = 1'b0;
        if (m_stale || redirect_valid) begin
          n_stale = 1'b0;
          if (redirect_valid) n_pc = t;
        end else begin
          n_held = 1'b1; n_inst = imem_resp_data; n_ipc = m_pc; n_pc = m_pc + 32'd4;
        end
      end else if (redirect_valid) begin
        n_pc = t; n_stale = 1'b1;
      end
    end else begin
      if (imem_req_ready) begin n_out = 1'b1; n_stale = redirect_valid; end
      if (redirect_valid) n_pc = t;
    end
    @(posedge clk); #1;
    m_started = n_started; m_out = n_out; m_stale = n_stale; m_held = n_held;
    m_halt = n_halt; m_pc = n_pc; m_inst = n_inst; m_ipc = n_ipc;
    imem_resp_valid = 1'b0;
    if (acc) begin rem = lat; pend_addr = acc_addr; end
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin imem_resp_valid = 1'b1; imem_resp_data = mem_word(pend_addr); end
    end
    if (stray) begin imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; stray = 1'b0; end
    w_resp_valid = w_acc;
    w_resp_data = ~w_addr;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("cmp_req_valid",  imem_req_valid, m_started & ~m_out & ~m_held & ~m_halt);
      chk32("cmp_req_addr",   imem_req_addr,  m_pc);
      chk1 ("cmp_inst_valid", inst_valid,     m_held);
      chk32("cmp_inst",       inst,           m_inst);
      chk32("cmp_inst_pc",    inst_pc,        m_ipc);
      chk1 ("cmp_fetch_error", fetch_error,   m_halt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset(2);
    chk_en = 1'b1;

    // reset sequence, 1-cycle memory
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    chk1 ("c0_req_valid", imem_req_valid, 1'b0);
    chk32("c0_addr", imem_req_addr, 32'h0000_0100);
    chk1 ("c0_inst_valid", inst_valid, 1'b0);
    chk32("c0_inst", inst, 32'd0);
    chk1 ("c0_fetch_error", fetch_error, 1'b0);
    tick();
    chk1 ("c1_req_valid", imem_req_valid, 1'b1);
    chk32("c1_addr", imem_req_addr, 32'h0000_0100);
    tick();
    chk1 ("c2_inst_valid", inst_valid, 1'b0);
    tick();
    chk1 ("c3_inst_valid", inst_valid, 1'b1);
    chk32("c3_inst", inst, 32'h0050_0093);
    chk32("c3_inst_pc", inst_pc, 32'h0000_0100);

    // decode backpressure
    repeat (5) begin
      tick();
      chk1 ("bp_inst_valid", inst_valid, 1'b1);
      chk32("bp_inst", inst, 32'h0050_0093);
      chk32("bp_inst_pc", inst_pc, 32'h0000_0100);
      chk1 ("bp_req_valid", imem_req_valid, 1'b0);
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk1 ("rel_req_valid", imem_req_valid, 1'b1);
    chk32("rel_addr", imem_req_addr, 32'h0000_0104);
    chk32("rel_consumed", hs_cnt, 32'd1);
    tick(); tick();
    chk1 ("i2_inst_valid", inst_valid, 1'b1);
    chk32("i2_inst", inst, 32'h0001_0413);
    chk32("i2_inst_pc", inst_pc, 32'h0000_0104);

    // redirect in HOLD without inst_ready: flush
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; tick(); redirect_valid = 1'b0;
    chk1 ("hflush_inst_valid", inst_valid, 1'b0);
    chk1 ("hflush_req_valid", imem_req_valid, 1'b1);
    chk32("hflush_addr", imem_req_addr, 32'h0000_0040);
    chk32("hflush_consumed", hs_cnt, 32'd1);
    tick(); tick();
    chk32("h40_inst", inst, 32'h0000_4013);
    chk32("h40_inst_pc", inst_pc, 32'h0000_0040);
    // same with inst_ready: consumed
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk1 ("hcons_inst_valid", inst_valid, 1'b0);
    chk32("hcons_addr", imem_req_addr, 32'h0000_0040);
    chk32("hcons_consumed", hs_cnt, 32'd2);
    chk32("hcons_model_consumed", hs_cnt, m_consumed);

    // redirect in REQ without acceptance
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; tick(); redirect_valid = 1'b0;
    chk1 ("rreq_req_valid", imem_req_valid, 1'b1);
    chk32("rreq_addr", imem_req_addr, 32'h0000_0200);

    // redirect in WAIT before a 3-cycle response
    lat = 3; imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    chk1 ("w_req_valid0", imem_req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0301; tick(); redirect_valid = 1'b0;
    chk32("w_addr_pending", imem_req_addr, 32'h0000_0300);
    tick();
    chk1 ("w_resp_inst_valid", inst_valid, 1'b0);
    tick();
    chk1 ("w_drop_inst_valid", inst_valid, 1'b0);
    chk1 ("w_drop_req_valid", imem_req_valid, 1'b1);
    chk32("w_drop_addr", imem_req_addr, 32'h0000_0300);

    // redirect in REQ coinciding with acceptance: old request killed
    lat = 1; imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500; tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    chk32("rk_addr", imem_req_addr, 32'h0000_0500);
    tick();
    chk1 ("rk_req_valid", imem_req_valid, 1'b1);
    chk1 ("rk_inst_valid", inst_valid, 1'b0);

    // redirect in WAIT together with the response
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0600; tick(); redirect_valid = 1'b0;
    chk1 ("wr_inst_valid", inst_valid, 1'b0);
    chk32("wr_addr", imem_req_addr, 32'h0000_0600);

    // stray response outside WAIT is ignored
    stray = 1'b1; tick(); tick();
    chk1 ("stray_inst_valid", inst_valid, 1'b0);
    chk1 ("stray_req_valid", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1; tick(); tick();
    chk32("f600_inst", inst, 32'h0006_0013);
    chk32("f600_inst_pc", inst_pc, 32'h0000_0600);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;

    // mixed pattern of stalls, latencies and redirects
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = (i % 3) != 0;
      inst_ready     = (i % 4) != 1;
      lat            = 1 + ((i / 50) % 3);
      redirect_valid = (i % 11) == 5;
      redirect_pc    = (32'(i) * 32'd16) + (TRAP_EN ? 32'd1 : 32'd3);
      tick();
    end
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk32("mix_consumed", hs_cnt, m_consumed);

    // misaligned redirect from HOLD
    do_reset(2);
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    tick(); tick(); tick();
    chk1 ("m_hold", inst_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; tick(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1 ("trap_error", fetch_error, 1'b1);
    chk32("trap_pc", imem_req_addr, 32'h0000_0102);
    repeat (5) begin
      tick();
      chk1("trap_req_valid", imem_req_valid, 1'b0);
      chk1("trap_error_held", fetch_error, 1'b1);
    end
    do_reset(2);
    chk1 ("trap_rst_error", fetch_error, 1'b0);
    tick();
    chk1 ("trap_rst_req_valid", imem_req_valid, 1'b1);
    chk32("trap_rst_addr", imem_req_addr, 32'h0000_0100);
`else
    chk1 ("noTrap_error", fetch_error, 1'b0);
    chk1 ("noTrap_req_valid", imem_req_valid, 1'b1);
    chk32("noTrap_addr", imem_req_addr, 32'h0000_0100);
`endif
    tick(); tick();

    // PC wrap on the second instance
    chk1("wrap_count", wq.size() >= 2 && wiq.size() >= 1, 1'b1);
    if (wq.size() >= 2 && wiq.size() >= 1) begin
      chk32("wrap_req0", wq[0], 32'hFFFF_FFFC);
      chk32("wrap_req1", wq[1], 32'h0000_0000);
      chk32("wrap_inst0", wiq[0], 32'h0000_0003);
      chk32("wrap_inst_pc0", wpq[0], 32'hFFFF_FFFC);
    end
    chk1("wrap_error", w_fetch_error, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
